voice_allocator: RTL and testbench

- Polyphonic voice controller between the MIDI decoder and an array of NUM_VOICES per-voice synthesis pipelines (oscillator + envelope each).
- Accepts note on/off events through a valid/ready handshake and assigns each note-on to a voice: a voice already holding that note, else a free voice, else the oldest voice (stolen).
- Emits one-cycle trigger/release pulses and holds the note number for each voice; frees a voice when that voice's envelope reports end of release.

---
 rtl/voice_allocator_pkg.sv | 30 +++
 rtl/voice_age_tracker.sv | 40 ++++
 rtl/voice_allocator.sv | 267 ++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// ----------------------------------------------------------------------------
// voice_allocator_pkg
// Shared types and constants for the polyphonic voice allocator.
//   voice_state_t  : per-voice lifecycle (FREE / HELD / RELEASING / SUSTAINED)
//   alloc_state_t  : allocator FSM states (IDLE -> SCAN -> COMMIT)
//   NOTE_WIDTH     : MIDI note number width
//   DEFAULT_*      : default parameter values for the allocator
// SUSTAINED is only ever entered when the design is built with
// SUSTAIN_PEDAL_EN defined.
// ----------------------------------------------------------------------------
package voice_allocator_pkg;

  localparam int NOTE_WIDTH         = 7;
  localparam int DEFAULT_NUM_VOICES = 8;
  localparam int DEFAULT_AGE_WIDTH  = 8;

  typedef enum logic [1:0] {
    VOICE_FREE      = 2'd0,
    VOICE_HELD      = 2'd1,
    VOICE_RELEASING = 2'd2,
    VOICE_SUSTAINED = 2'd3
  } voice_state_t;

  typedef enum logic [1:0] {
    ALLOC_IDLE   = 2'd0,
    ALLOC_SCAN   = 2'd1,
    ALLOC_COMMIT = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/voice_age_tracker.sv
// ----------------------------------------------------------------------------
// voice_age_tracker
// Per-voice saturating age counters. A voice's age counts how many note-on
// commits have happened since it was last (re)triggered; the allocator
// steals the voice with the largest age when every voice is busy.
// Ports:
//   clk      : clock
//   reset_l  : asynchronous active-low reset, clears all ages to 0
//   clear    : per-voice, forces the age to 0 (wins over incr)
//   incr     : per-voice, increments the age, saturating at all ones
//   ages     : packed ages, voice i at [i*AGE_WIDTH +: AGE_WIDTH]
// ----------------------------------------------------------------------------
module voice_age_tracker #(
  parameter int NUM_VOICES = 8,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset_l,
  input  logic [NUM_VOICES-1:0]           clear,
  input  logic [NUM_VOICES-1:0]           incr,
  output logic [NUM_VOICES*AGE_WIDTH-1:0] ages
);

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_age
    logic [AGE_WIDTH-1:0] age_reg;

    always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
        age_reg <= '0;
      end else if (clear[gi]) begin
        age_reg <= '0;
      end else if (incr[gi] && (age_reg != {AGE_WIDTH{1'b1}})) begin
        age_reg <= age_reg + 1'b1;
      end
    end

    assign ages[gi*AGE_WIDTH +: AGE_WIDTH] = age_reg;
  end

endmodule

// File: rtl/voice_allocator.sv
// ----------------------------------------------------------------------------
// voice_allocator
// Polyphonic voice controller. Accepts note on/off events over a valid/ready
// handshake, scans the voices one per cycle, then commits: a note-on goes to
// the voice already holding that note, else the lowest free voice, else the
// oldest voice (stolen). Emits one-cycle trigger/release pulses and holds the
// note number of each voice. A voice is freed when its envelope reports end
// of release.
// Optional feature macro: SUSTAIN_PEDAL_EN adds the 'sustain' input and the
// SUSTAINED voice state (note-offs deferred until the pedal is lifted).
// Ports:
//   clock_50_000_000   : system clock
//   reset_l            : asynchronous active-low reset
//   sustain            : (SUSTAIN_PEDAL_EN only) pedal level, 1 = held
//   note_valid/ready   : event handshake, ready only in IDLE
//   note_on            : 1 = note on, 0 = note off
//   note_number        : MIDI note number
//   voice_envelope_end : per-voice pulse, release phase finished
//   voice_trigger      : per-voice pulse, start/restart voice
//   voice_release      : per-voice pulse, enter release
//   voice_note         : note number per voice, voice i at [i*7 +: 7]
//   voice_active       : per-voice, state != FREE
// Timing: event accepted in cycle 0, voices scanned in cycles 1..NUM_VOICES,
// commit pulses in cycle NUM_VOICES+1, ready again in cycle NUM_VOICES+2.
// ----------------------------------------------------------------------------
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int AGE_WIDTH  = DEFAULT_AGE_WIDTH
) (
  input  logic                             clock_50_000_000,
  input  logic                             reset_l,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                             sustain,
`endif
  input  logic                             note_valid,
  output logic                             note_ready,
  input  logic                             note_on,
  input  logic [NOTE_WIDTH-1:0]            note_number,
  input  logic [NUM_VOICES-1:0]            voice_envelope_end,
  output logic [NUM_VOICES-1:0]            voice_trigger,
  output logic [NUM_VOICES-1:0]            voice_release,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
  output logic [NUM_VOICES-1:0]            voice_active
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  alloc_state_t state_reg, state_next;

  // Latched event and scan results
  logic                  event_on_reg;
  logic [NOTE_WIDTH-1:0] event_note_reg;
  logic [IDX_W-1:0]      scan_idx_reg;
  logic                  match_found_reg;
  logic [IDX_W-1:0]      match_idx_reg;
  logic                  free_found_reg;
  logic [IDX_W-1:0]      free_idx_reg;
  logic [IDX_W-1:0]      oldest_idx_reg;
  logic [AGE_WIDTH-1:0]  oldest_age_reg;

  // Per-voice state
  voice_state_t          vstate_reg [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] vnote_reg  [NUM_VOICES];

  logic [NUM_VOICES*AGE_WIDTH-1:0] ages;
  logic [NUM_VOICES-1:0]           age_clear;
  logic [NUM_VOICES-1:0]           age_incr;

  logic [NUM_VOICES-1:0] trigger_hit;
  logic [NUM_VOICES-1:0] release_hit;
  logic [NUM_VOICES-1:0] sustain_hit;
  logic [NUM_VOICES-1:0] pedal_hit;

  logic                  is_commit;
  logic                  match_held;
  logic                  do_trigger;
  logic                  do_release;
  logic                  do_sustain;
  logic                  pedal_fall;
  logic [IDX_W-1:0]      target_idx;

  voice_state_t          scan_state;
  logic [NOTE_WIDTH-1:0] scan_note;
  logic [AGE_WIDTH-1:0]  scan_age;

  // --------------------------------------------------------------------------
  // Allocator FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_reg <= ALLOC_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    note_ready = 1'b0;
    unique case (state_reg)
      ALLOC_IDLE: begin
        // Gated with reset_l so ready stays low while reset is held.
        note_ready = reset_l;
        if (note_valid) begin
          state_next = ALLOC_SCAN;
        end
      end
      ALLOC_SCAN: begin
        if (scan_idx_reg == IDX_W'(NUM_VOICES - 1)) begin
          state_next = ALLOC_COMMIT;
        end
      end
      ALLOC_COMMIT: begin
        state_next = ALLOC_IDLE;
      end
      default: begin
        state_next = ALLOC_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Event latch and sequential voice scan
  // --------------------------------------------------------------------------
  assign scan_state = vstate_reg[scan_idx_reg];
  assign scan_note  = vnote_reg[scan_idx_reg];
  assign scan_age   = ages[scan_idx_reg*AGE_WIDTH +: AGE_WIDTH];

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      event_on_reg    <= 1'b0;
      event_note_reg  <= '0;
      scan_idx_reg    <= '0;
      match_found_reg <= 1'b0;
      match_idx_reg   <= '0;
      free_found_reg  <= 1'b0;
      free_idx_reg    <= '0;
      oldest_idx_reg  <= '0;
      oldest_age_reg  <= '0;
    end else begin
      unique case (state_reg)
        ALLOC_IDLE: begin
          if (note_valid) begin
            event_on_reg    <= note_on;
            event_note_reg  <= note_number;
            scan_idx_reg    <= '0;
            match_found_reg <= 1'b0;
            free_found_reg  <= 1'b0;
            oldest_idx_reg  <= '0;
            oldest_age_reg  <= '0;
          end
        end
        ALLOC_SCAN: begin
          if (!match_found_reg && (scan_state != VOICE_FREE) &&
              (scan_note == event_note_reg)) begin
            match_found_reg <= 1'b1;
            match_idx_reg   <= scan_idx_reg;
          end
          if (!free_found_reg && (scan_state == VOICE_FREE)) begin
            free_found_reg <= 1'b1;
            free_idx_reg   <= scan_idx_reg;
          end
          // Strict compare keeps the lowest index on equal ages.
          if ((scan_idx_reg == '0) || (scan_age > oldest_age_reg)) begin
            oldest_idx_reg <= scan_idx_reg;
            oldest_age_reg <= scan_age;
          end
          scan_idx_reg <= scan_idx_reg + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Commit decode
  // --------------------------------------------------------------------------
  assign is_commit  = (state_reg == ALLOC_COMMIT);
  assign match_held = match_found_reg && (vstate_reg[match_idx_reg] == VOICE_HELD);
  assign do_trigger = is_commit && event_on_reg;

  always_comb begin
    target_idx = match_idx_reg;
    if (event_on_reg && !match_found_reg) begin
      target_idx = free_found_reg ? free_idx_reg : oldest_idx_reg;
    end
  end

`ifdef SUSTAIN_PEDAL_EN
  logic sustain_prev_reg;

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      sustain_prev_reg <= 1'b0;
    end else begin
      sustain_prev_reg <= sustain;
    end
  end

  assign pedal_fall = sustain_prev_reg && !sustain;
  assign do_release = is_commit && !event_on_reg && match_held && !sustain;
  assign do_sustain = is_commit && !event_on_reg && match_held && sustain;
`else
  assign pedal_fall = 1'b0;
  assign do_release = is_commit && !event_on_reg && match_held;
  assign do_sustain = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign trigger_hit[gi] = do_trigger && (target_idx == IDX_W'(gi));
    assign release_hit[gi] = do_release && (target_idx == IDX_W'(gi));
    assign sustain_hit[gi] = do_sustain && (target_idx == IDX_W'(gi));
    // The commit's own target is never released by the pedal in the same cycle.
    assign pedal_hit[gi]   = pedal_fall && (vstate_reg[gi] == VOICE_SUSTAINED) &&
                             !(trigger_hit[gi] || release_hit[gi] || sustain_hit[gi]);

    assign voice_trigger[gi] = trigger_hit[gi];
    assign voice_release[gi] = release_hit[gi] || pedal_hit[gi];
    assign voice_active[gi]  = (vstate_reg[gi] != VOICE_FREE);
    assign voice_note[gi*NOTE_WIDTH +: NOTE_WIDTH] = vnote_reg[gi];

    assign age_clear[gi] = trigger_hit[gi];
    assign age_incr[gi]  = do_trigger && !trigger_hit[gi] &&
                           (vstate_reg[gi] != VOICE_FREE);
  end

  // --------------------------------------------------------------------------
  // Per-voice state. Trigger has priority, so an envelope end arriving on
  // the cycle a voice is retriggered leaves it HELD.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate_reg[i] <= VOICE_FREE;
        vnote_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (trigger_hit[i]) begin
          vstate_reg[i] <= VOICE_HELD;
          vnote_reg[i]  <= event_note_reg;
        end else if (release_hit[i] || pedal_hit[i]) begin
          vstate_reg[i] <= VOICE_RELEASING;
        end else if (sustain_hit[i]) begin
          vstate_reg[i] <= VOICE_SUSTAINED;
        end else if (voice_envelope_end[i] && (vstate_reg[i] == VOICE_RELEASING)) begin
          vstate_reg[i] <= VOICE_FREE;
        end
      end
    end
  end

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_WIDTH  (AGE_WIDTH)
  ) u_age_tracker (
    .clk     (clock_50_000_000),
    .reset_l (reset_l),
    .clear   (age_clear),
    .incr    (age_incr),
    .ages    (ages)
  );

endmodule

// File: tb/tb_voice_allocator.sv
// ----------------------------------------------------------------------------
// tb_voice_allocator
// Scoreboard bench for voice_allocator with NUM_VOICES = 4. The driver pushes
// the expected commit (cycle, trigger, release, resulting voice_active and
// note) when an event is accepted; a monitor pops and compares whenever the
// DUT pulses trigger or release. Build with SUSTAIN_PEDAL_EN to also run the
// pedal sequence.
// ----------------------------------------------------------------------------
module tb_voice_allocator;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          reset_l;
  logic          note_valid;
  logic          note_ready;
  logic          note_on;
  logic [6:0]    note_number;
  logic [NV-1:0] voice_envelope_end;
  logic [NV-1:0] voice_trigger;
  logic [NV-1:0] voice_release;
  logic [NV*7-1:0] voice_note;
  logic [NV-1:0] voice_active;
`ifdef SUSTAIN_PEDAL_EN
  logic          sustain;
`endif

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES (NV),
    .AGE_WIDTH  (8)
  ) dut (
    .clock_50_000_000   (clk),
    .reset_l            (reset_l),
`ifdef SUSTAIN_PEDAL_EN
    .sustain            (sustain),
`endif
    .note_valid         (note_valid),
    .note_ready         (note_ready),
    .note_on            (note_on),
    .note_number        (note_number),
    .voice_envelope_end (voice_envelope_end),
    .voice_trigger      (voice_trigger),
    .voice_release      (voice_release),
    .voice_note         (voice_note),
    .voice_active       (voice_active)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  trig;
    logic [3:0]  rel;
    logic [3:0]  act;
    int          nidx;
    logic        chk_note;
    logic [6:0]  note;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  // Call at a negedge. Returns at the negedge after acceptance.
  task automatic send(input logic on, input logic [6:0] num, input logic has_exp,
                      input logic [3:0] trig, input logic [3:0] rel,
                      input logic [3:0] act, input int nidx, input logic chk_note,
                      input logic hold, output int acc_cyc);
    exp_t e;
    int   waitc;
    note_valid  = 1'b1;
    note_on     = on;
    note_number = num;
    waitc = 0;
    while (!note_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    acc_cyc = cyc;
    if (!note_ready) begin
      chk("ready_timeout", 0, 1);
    end else if (has_exp) begin
      e.cyc = cyc + NV + 1;
      e.trig = trig;
      e.rel = rel;
      e.act = act;
      e.nidx = nidx;
      e.chk_note = chk_note;
      e.note = num;
      exp_q.push_back(e);
    end
    $display("send %s note=%0d accepted cycle %0d", on ? "on " : "off", num, acc_cyc);
    @(negedge clk);
    if (!hold) note_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waitc;
    waitc = 0;
    while (!(note_ready && exp_q.size() == 0) && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!(note_ready && exp_q.size() == 0)) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic env(input logic [3:0] v);
    voice_envelope_end = v;
    @(negedge clk);
    voice_envelope_end = '0;
  endtask

  // Monitor: compares every trigger/release pulse against the scoreboard.
  initial begin
    exp_t e;
    logic [3:0] t_s, r_s;
    forever begin
      @(negedge clk);
      if (reset_l && (voice_trigger != 0 || voice_release != 0)) begin
        t_s = voice_trigger;
        r_s = voice_release;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {t_s, r_s}, 0);
        end else begin
          e = exp_q.pop_front();
          $display("pulse cycle %0d trigger=%b release=%b", cyc, t_s, r_s);
          chk("pulse_cycle", cyc, e.cyc);
          chk("trigger", int'(t_s), int'(e.trig));
          chk("release", int'(r_s), int'(e.rel));
          @(negedge clk);
          chk("active_after", int'(voice_active), int'(e.act));
          if (e.chk_note) chk("voice_note", int'(voice_note[e.nidx*7 +: 7]), int'(e.note));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int a, a1, a2, a3;
    reset_l = 1'b0;
    note_valid = 1'b0;
    note_on = 1'b0;
    note_number = '0;
    voice_envelope_end = '0;
`ifdef SUSTAIN_PEDAL_EN
    sustain = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ready", note_ready, 0);
    chk("reset_active", voice_active, 0);
    chk("reset_trigger", voice_trigger, 0);
    chk("reset_release", voice_release, 0);
    chk("reset_note", voice_note, 0);
    reset_l = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", note_ready, 1);

    // First note, then retrigger of the same note
    send(1, 60, 1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, a); wait_idle();
    send(1, 60, 1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, a); wait_idle();
    // Note off, then envelope end frees the voice
    send(0, 60, 1, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0, a); wait_idle();
    env(4'b0001);
    chk("env_free", voice_active, 0);
    chk("note_retained", voice_note[6:0], 60);
    // Unheld note off is dropped
    send(0, 61, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, a); wait_idle();
    chk("drop_active", voice_active, 0);

    // Fill all voices, then steal the oldest twice
    send(1, 60, 1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, a); wait_idle();
    send(1, 64, 1, 4'b0010, 4'b0000, 4'b0011, 1, 1, 0, a); wait_idle();
    send(1, 67, 1, 4'b0100, 4'b0000, 4'b0111, 2, 1, 0, a); wait_idle();
    send(1, 72, 1, 4'b1000, 4'b0000, 4'b1111, 3, 1, 0, a); wait_idle();
    send(1, 76, 1, 4'b0001, 4'b0000, 4'b1111, 0, 1, 0, a); wait_idle();
    send(1, 80, 1, 4'b0010, 4'b0000, 4'b1111, 1, 1, 0, a); wait_idle();

    // note_valid held high across three back-to-back events
    send(0, 76, 1, 4'b0000, 4'b0001, 4'b1111, 0, 0, 1, a1);
    send(0, 80, 1, 4'b0000, 4'b0010, 4'b1111, 1, 0, 1, a2);
    send(1, 67, 1, 4'b0100, 4'b0000, 4'b1111, 2, 1, 0, a3);
    chk("accept_spacing_1", a2 - a1, NV + 2);
    chk("accept_spacing_2", a3 - a2, NV + 2);
    wait_idle();

    // Envelope end frees releasing voices, ignored on held ones
    env(4'b0011);
    chk("env_free_two", voice_active, 4'b1100);
    env(4'b1000);
    chk("env_ignored_held", voice_active, 4'b1100);

    // Free voice preferred, releasing voice with same note is re-used
    send(1, 90, 1, 4'b0001, 4'b0000, 4'b1101, 0, 1, 0, a); wait_idle();
    send(0, 72, 1, 4'b0000, 4'b1000, 4'b1101, 3, 1, 0, a); wait_idle();
    send(1, 72, 1, 4'b1000, 4'b0000, 4'b1101, 3, 1, 0, a); wait_idle();

    // Reset during the scan discards the event
    send(1, 100, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, a);
    @(negedge clk);
    reset_l = 1'b0;
    @(negedge clk);
    chk("midscan_reset_ready", note_ready, 0);
    chk("midscan_reset_active", voice_active, 0);
    reset_l = 1'b1;
    repeat (8) @(negedge clk);
    chk("midscan_discard_active", voice_active, 0);
    chk("midscan_discard_note", voice_note, 0);
    chk("midscan_ready", note_ready, 1);

`ifdef SUSTAIN_PEDAL_EN
    begin
      exp_t e;
      sustain = 1'b1;
      send(1, 60, 1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, a); wait_idle();
      send(1, 64, 1, 4'b0010, 4'b0000, 4'b0011, 1, 1, 0, a); wait_idle();
      send(0, 60, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, a); wait_idle();
      send(0, 64, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, a); wait_idle();
      chk("sustained_active", voice_active, 4'b0011);
      @(posedge clk);
      #1;
      e.cyc = cyc;
      e.trig = 4'b0000;
      e.rel = 4'b0011;
      e.act = 4'b0011;
      e.nidx = 0;
      e.chk_note = 1'b0;
      e.note = 7'd0;
      exp_q.push_back(e);
      sustain = 1'b0;
      repeat (4) @(negedge clk);
    end
`endif

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
